// File: rtl/zbuf_pkg.sv
// Shared types and widths for the depth-buffered pixel writer.
// Holds the FSM state enum, bus widths and the far-plane depth constant.
package zbuf_pkg;

  localparam int ADDR_W  = 26;
  localparam int COLOR_W = 24;
  localparam int DEPTH_W = 32;

  localparam logic [DEPTH_W-1:0] DEPTH_FAR = 32'h7FFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_Z,
    WAIT_Z,
    WR_Z,
    WR_C
  } state_t;

endpackage

// File: rtl/zbuf_writer.sv
// Z-buffered pixel writer: per pixel, optionally read/compare depth,
// then write depth and colour over a waitrequest memory bus.
// Ports: clock, reset (async, active-low); pixel in (pix_addr,
// pix_color, pix_depth, pix_valid/pix_stall); done_in -> done_out
// pulse; memory master (mem_addr, mem_read, mem_write, mem_wdata,
// mem_waitrequest, mem_rdata, mem_rvalid); pix_written and
// pix_rejected statistics counters.
// Macro ZBUF_DEPTH_TEST_EN enables the depth read and compare; when it
// is undefined every pixel is written unconditionally.
module zbuf_writer
  import zbuf_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEPTH_OFFSET = 26'h0100000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pix_addr,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic [DEPTH_W-1:0] pix_depth,
  input  logic               pix_valid,
  output logic               pix_stall,
  input  logic               done_in,
  output logic               done_out,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_wdata,
  input  logic               mem_waitrequest,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rvalid,
  output logic [31:0]        pix_written,
  output logic [31:0]        pix_rejected
);

  state_t             state;
  logic [ADDR_W-1:0]  lat_addr;
  logic [COLOR_W-1:0] lat_color;
  logic [DEPTH_W-1:0] lat_depth;
  logic               done_pend;

  logic accept;
  logic fire;
  logic closer;

  assign accept = (state == IDLE) && pix_valid;
  // Done may only leave once no pixel is in flight or being taken.
  assign fire   = done_pend && (state == IDLE) && !accept;
  assign closer = $signed(lat_depth) < $signed(mem_rdata);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_color    <= '0;
      lat_depth    <= '0;
      done_pend    <= 1'b0;
      done_out     <= 1'b0;
      pix_stall    <= 1'b0;
      mem_addr     <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      pix_written  <= '0;
      pix_rejected <= '0;
    end else begin
      done_out  <= fire;
      done_pend <= fire ? done_in : (done_pend | done_in);

      unique case (state)
        IDLE: begin
          if (pix_valid) begin
            lat_addr  <= pix_addr;
            lat_color <= pix_color;
            lat_depth <= pix_depth;
            pix_stall <= 1'b1;
            mem_addr  <= pix_addr + DEPTH_OFFSET;
`ifdef ZBUF_DEPTH_TEST_EN
            state     <= RD_Z;
            mem_read  <= 1'b1;
`else
            state     <= WR_Z;
            mem_write <= 1'b1;
            mem_wdata <= pix_depth;
`endif
          end
        end
        RD_Z: begin
          if (!mem_waitrequest) begin
            state    <= WAIT_Z;
            mem_read <= 1'b0;
          end
        end
        WAIT_Z: begin
          if (mem_rvalid) begin
            if (closer) begin
              state     <= WR_Z;
              mem_write <= 1'b1;
              mem_wdata <= lat_depth;
            end else begin
              state        <= IDLE;
              pix_stall    <= 1'b0;
              pix_rejected <= pix_rejected + 32'd1;
            end
          end
        end
        WR_Z: begin
          if (!mem_waitrequest) begin
            state     <= WR_C;
            mem_addr  <= lat_addr;
            mem_wdata <= {8'h00, lat_color};
          end
        end
        WR_C: begin
          if (!mem_waitrequest) begin
            state       <= IDLE;
            mem_write   <= 1'b0;
            pix_stall   <= 1'b0;
            pix_written <= pix_written + 32'd1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          pix_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zbuf_writer.sv
// Directed self-checking bench for zbuf_writer.
// A behavioural memory on negedge supplies waitrequest, rvalid and logs writes.
module tb_zbuf_writer;

  localparam logic [25:0] OFF = 26'h0100000;
`ifdef ZBUF_DEPTH_TEST_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [25:0] pix_addr;
  logic [23:0] pix_color;
  logic [31:0] pix_depth;
  logic        pix_valid;
  logic        pix_stall;
  logic        done_in;
  logic        done_out;
  logic [25:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] pix_written;
  logic [31:0] pix_rejected;

  zbuf_writer #(.DEPTH_OFFSET(OFF)) dut (
    .clock(clock), .reset(reset),
    .pix_addr(pix_addr), .pix_color(pix_color),
    .pix_depth(pix_depth), .pix_valid(pix_valid),
    .pix_stall(pix_stall), .done_in(done_in),
    .done_out(done_out), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_waitrequest(mem_waitrequest),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .pix_written(pix_written),
    .pix_rejected(pix_rejected)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] stored = 32'h0;
  assign mem_rdata = stored;

  int rd_wait = 0, wz_wait = 0, wc_wait = 0;
  int wcnt = 0;
  bit started = 0, rd_fire = 0;
  int n_rd = 0, n_both = 0, n_unstable = 0, n_done = 0;
  int done_cyc = 0, comp_cyc = 0, acc_cyc = 0;
  logic [31:0] last_w = 32'h0;
  logic [25:0] hold_a;
  logic [31:0] hold_d;
  logic [25:0] wq_a[$];
  logic [31:0] wq_d[$];

  always @(negedge clock) begin
    mem_rvalid = rd_fire;
    rd_fire = 1'b0;
    if (done_out) begin n_done++; done_cyc = cyc; end
    if (pix_written !== last_w) begin
      comp_cyc = cyc;
      last_w = pix_written;
    end
    if (mem_read && mem_write) n_both++;
    if (mem_read) n_rd++;
    if (!(mem_read || mem_write)) begin
      started = 1'b0;
      mem_waitrequest = 1'b0;
    end else begin
      if (!started) begin
        started = 1'b1;
        hold_a = mem_addr;
        hold_d = mem_wdata;
        wcnt = mem_read ? rd_wait :
               (mem_addr >= OFF ? wz_wait : wc_wait);
      end else if (mem_addr !== hold_a ||
                   (mem_write && mem_wdata !== hold_d)) begin
        n_unstable++;
      end
      if (wcnt > 0) begin
        mem_waitrequest = 1'b1;
        wcnt--;
      end else begin
        mem_waitrequest = 1'b0;
        started = 1'b0;
        if (mem_read) rd_fire = 1'b1;
        else begin
          wq_a.push_back(mem_addr);
          wq_d.push_back(mem_wdata);
        end
      end
    end
  end

  task automatic clear_q();
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic pad_q();
    while (wq_a.size() < 4) begin
      wq_a.push_back(26'h0);
      wq_d.push_back(32'h0);
    end
  endtask

  task automatic present(input logic [25:0] a,
                         input logic [23:0] c,
                         input logic [31:0] d,
                         input logic dn);
    int k;
    k = 0;
    pix_addr = a;
    pix_color = c;
    pix_depth = d;
    pix_valid = 1'b1;
    done_in = dn;
    while (pix_stall && k < 300) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (k >= 300) begin
      bad++;
      $display("FAIL accept_timeout got=stalled want=accepted");
    end
    acc_cyc = cyc + 1;
    @(negedge clock);
    pix_valid = 1'b0;
    done_in = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (pix_stall && k < 300) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (k >= 300) begin
      bad++;
      $display("FAIL idle_timeout got=stalled want=idle");
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    total += 8;
    if (pix_stall !== 1'b0) begin bad++;
      $display("FAIL rst_stall got=%b want=0", pix_stall); end
    if (mem_read !== 1'b0) begin bad++;
      $display("FAIL rst_read got=%b want=0", mem_read); end
    if (mem_write !== 1'b0) begin bad++;
      $display("FAIL rst_write got=%b want=0", mem_write); end
    if (mem_addr !== 26'h0) begin bad++;
      $display("FAIL rst_addr got=%h want=0", mem_addr); end
    if (mem_wdata !== 32'h0) begin bad++;
      $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
    if (done_out !== 1'b0) begin bad++;
      $display("FAIL rst_done got=%b want=0", done_out); end
    if (pix_written !== 32'h0) begin bad++;
      $display("FAIL rst_written got=%h want=0", pix_written); end
    if (pix_rejected !== 32'h0) begin bad++;
      $display("FAIL rst_rejected got=%h want=0", pix_rejected); end
  endtask

  task automatic test_basic();
    int nr0, lat, sz;
    stored = 32'h00050000;
    clear_q();
    nr0 = n_rd;
    present(26'h000010, 24'hFF8000, 32'h00020000, 1'b0);
    wait_idle();
    lat = comp_cyc - acc_cyc + 1;
    sz = wq_a.size();
    pad_q();
    total += 10;
    if (sz != 2) begin bad++;
      $display("FAIL basic_nwr got=%0d want=2", sz); end
    if (wq_a[0] !== 26'h0100010) begin bad++;
      $display("FAIL basic_z_addr got=%h want=0100010", wq_a[0]); end
    if (wq_d[0] !== 32'h00020000) begin bad++;
      $display("FAIL basic_z_data got=%h want=00020000", wq_d[0]); end
    if (wq_a[1] !== 26'h0000010) begin bad++;
      $display("FAIL basic_c_addr got=%h want=0000010", wq_a[1]); end
    if (wq_d[1] !== 32'h00FF8000) begin bad++;
      $display("FAIL basic_c_data got=%h want=00FF8000", wq_d[1]); end
    if (pix_written !== 32'd1) begin bad++;
      $display("FAIL basic_written got=%0d want=1", pix_written); end
    if (pix_rejected !== 32'd0) begin bad++;
      $display("FAIL basic_rejected got=%0d want=0", pix_rejected); end
    if (lat != (DT ? 5 : 3)) begin bad++;
      $display("FAIL basic_latency got=%0d want=%0d", lat, DT ? 5 : 3); end
    if (n_rd - nr0 != (DT ? 1 : 0)) begin bad++;
      $display("FAIL basic_reads got=%0d want=%0d", n_rd - nr0, DT ? 1 : 0); end
    if (n_both != 0) begin bad++;
      $display("FAIL basic_rd_wr_overlap got=%0d want=0", n_both); end
  endtask

  task automatic test_compare();
    logic [31:0] vs[5];
    logic [31:0] vd[5];
    bit vw[5];
    vs = '{32'h00010000, 32'h00020000, 32'h00010000,
           32'hFFFF0000, 32'h7FFFFFFF};
    vd = '{32'h00020000, 32'h00020000, 32'hFFFF0000,
           32'h00010000, 32'h7FFFFFFE};
    vw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      logic [31:0] w0, r0;
      int ew, sz;
      stored = vs[i];
      clear_q();
      w0 = pix_written;
      r0 = pix_rejected;
      present(26'h20 + 26'(i), 24'h123450 + 24'(i), vd[i], 1'b0);
      wait_idle();
      ew = DT ? int'(vw[i]) : 1;
      sz = wq_a.size();
      pad_q();
      total += 5;
      if (sz != ew * 2) begin bad++;
        $display("FAIL cmp%0d_nwr got=%0d want=%0d", i, sz, ew * 2); end
      if (pix_written - w0 != 32'(ew)) begin bad++;
        $display("FAIL cmp%0d_written got=%0d want=%0d", i, pix_written - w0, ew); end
      if (pix_rejected - r0 != 32'(1 - ew)) begin bad++;
        $display("FAIL cmp%0d_rejected got=%0d want=%0d", i, pix_rejected - r0, 1 - ew); end
      if (pix_stall !== 1'b0) begin bad++;
        $display("FAIL cmp%0d_stall got=%b want=0", i, pix_stall); end
      if (wq_d[0] !== (ew == 1 ? vd[i] : 32'h0)) begin bad++;
        $display("FAIL cmp%0d_zdata got=%h want=%h", i, wq_d[0], ew == 1 ? vd[i] : 32'h0); end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, c1, c2, nu0, sz;
    logic [31:0] w0;
    stored = 32'h00050000;
    rd_wait = 3;
    wc_wait = 3;
    clear_q();
    nu0 = n_unstable;
    w0 = pix_written;
    present(26'h000030, 24'hAABBCC, 32'h00010000, 1'b0);
    a1 = acc_cyc;
    present(26'h000031, 24'h112233, 32'h00010000, 1'b0);
    a2 = acc_cyc;
    c1 = comp_cyc;
    wait_idle();
    c2 = comp_cyc;
    rd_wait = 0;
    wc_wait = 0;
    sz = wq_a.size();
    pad_q();
    total += 7;
    if (c1 - a1 + 1 != (DT ? 11 : 6)) begin bad++;
      $display("FAIL b2b_latency got=%0d want=%0d", c1 - a1 + 1, DT ? 11 : 6); end
    if (a2 != c1 + 1) begin bad++;
      $display("FAIL b2b_accept2 got=%0d want=%0d", a2, c1 + 1); end
    if (c2 - a2 + 1 != (DT ? 11 : 6)) begin bad++;
      $display("FAIL b2b_latency2 got=%0d want=%0d", c2 - a2 + 1, DT ? 11 : 6); end
    if (n_unstable != nu0) begin bad++;
      $display("FAIL b2b_stable got=%0d want=%0d", n_unstable, nu0); end
    if (sz != 4) begin bad++;
      $display("FAIL b2b_nwr got=%0d want=4", sz); end
    if (pix_written - w0 != 32'd2) begin bad++;
      $display("FAIL b2b_written got=%0d want=2", pix_written - w0); end
    if (wq_a[3] !== 26'h31 || wq_d[3] !== 32'h00112233) begin bad++;
      $display("FAIL b2b_c2 got=%h/%h want=31/00112233", wq_a[3], wq_d[3]); end
  endtask

  task automatic test_done();
    int n0, l;
    n0 = n_done;
    done_in = 1'b1;
    l = cyc + 1;
    @(negedge clock);
    done_in = 1'b0;
    repeat (4) @(negedge clock);
    total += 2;
    if (n_done != n0 + 1) begin bad++;
      $display("FAIL done_idle_count got=%0d want=%0d", n_done, n0 + 1); end
    if (done_cyc != l + 1) begin bad++;
      $display("FAIL done_idle_when got=%0d want=%0d", done_cyc, l + 1); end
    stored = 32'h00050000;
    n0 = n_done;
    present(26'h000040, 24'h00CC00, 32'h00010000, 1'b1);
    wait_idle();
    repeat (3) @(negedge clock);
    total += 2;
    if (n_done != n0 + 1) begin bad++;
      $display("FAIL done_pix_count got=%0d want=%0d", n_done, n0 + 1); end
    if (done_cyc != comp_cyc + 1) begin bad++;
      $display("FAIL done_pix_when got=%0d want=%0d", done_cyc, comp_cyc + 1); end
  endtask

  task automatic test_async_reset();
    int sz;
    stored = 32'h00050000;
    wz_wait = 20;
    clear_q();
    present(26'h000050, 24'h0F0F0F, 32'h00010000, 1'b0);
    repeat (3) @(negedge clock);
    total++;
    if (mem_write !== 1'b1) begin bad++;
      $display("FAIL ar_pre_write got=%b want=1", mem_write); end
    #2 reset = 1'b0;
    #1;
    total += 5;
    if (mem_write !== 1'b0) begin bad++;
      $display("FAIL ar_write got=%b want=0", mem_write); end
    if (pix_stall !== 1'b0) begin bad++;
      $display("FAIL ar_stall got=%b want=0", pix_stall); end
    if (mem_addr !== 26'h0) begin bad++;
      $display("FAIL ar_addr got=%h want=0", mem_addr); end
    if (pix_written !== 32'h0) begin bad++;
      $display("FAIL ar_written got=%0d want=0", pix_written); end
    if (pix_rejected !== 32'h0) begin bad++;
      $display("FAIL ar_rejected got=%0d want=0", pix_rejected); end
    @(negedge clock);
    reset = 1'b1;
    wz_wait = 0;
    repeat (10) @(negedge clock);
    sz = wq_a.size();
    total += 2;
    if (sz != 0) begin bad++;
      $display("FAIL ar_ghost_wr got=%0d want=0", sz); end
    if (pix_written !== 32'h0) begin bad++;
      $display("FAIL ar_written_after got=%0d want=0", pix_written); end
    present(26'h000060, 24'h010203, 32'h00010000, 1'b0);
    wait_idle();
    sz = wq_a.size();
    pad_q();
    total += 2;
    if (pix_written !== 32'd1) begin bad++;
      $display("FAIL ar_resume got=%0d want=1", pix_written); end
    if (sz != 2 || wq_d[1] !== 32'h00010203) begin bad++;
      $display("FAIL ar_resume_wr got=%0d/%h want=2/00010203", sz, wq_d[1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    pix_addr = '0;
    pix_color = '0;
    pix_depth = '0;
    pix_valid = 1'b0;
    done_in = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_basic();
    test_compare();
    test_back_to_back();
    test_done();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zbuf_writer.md
ZBUF_WRITER -- requirements
Module: zbuf_writer

Interface
REQ-001 SHALL have parameter DEPTH_OFFSET, default 26'h0100000, word offset from a pixel's colour address to its depth address.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports pix_addr input 26 (colour address); pix_color input 24 (RGB); pix_depth input 32 (signed 16.16).
REQ-005 SHALL have ports pix_valid input 1 and pix_stall output 1; a pixel is accepted on a rising edge where pix_valid=1 and pix_stall=0.
REQ-006 SHALL have ports done_in input 1 (end of triangle from upstream) and done_out output 1 (one-cycle pulse).
REQ-007 SHALL have memory ports mem_addr output 26, mem_read output 1, mem_write output 1, mem_wdata output 32, mem_waitrequest input 1, mem_rdata input 32, mem_rvalid input 1.
REQ-008 SHALL have ports pix_written output 32 and pix_rejected output 32 (statistics counters).

Function
REQ-009 SHALL implement FSM states IDLE, RD_Z, WAIT_Z, WR_Z, WR_C.
REQ-010 SHALL drive pix_stall=1 in every state except IDLE.
REQ-011 IDLE: on acceptance, SHALL latch addr, color and depth, then go to RD_Z.
REQ-012 RD_Z: SHALL drive mem_read=1 and mem_addr=addr+DEPTH_OFFSET (mod 2^26); go to WAIT_Z on the first edge with mem_waitrequest=0.
REQ-013 WAIT_Z: SHALL hold until mem_rvalid=1, then compare signed: new depth < mem_rdata -> WR_Z; otherwise -> IDLE and increment pix_rejected.
REQ-014 Equal depth SHALL be rejected (strict less-than).
REQ-015 WR_Z: SHALL drive mem_write=1, mem_addr=depth address, mem_wdata=new depth; hold until mem_waitrequest=0, then go to WR_C.
REQ-016 WR_C: SHALL drive mem_write=1, mem_addr=addr, mem_wdata={8'h00,color}; on mem_waitrequest=0 go to IDLE and increment pix_written.
REQ-017 mem_read and mem_write SHALL never be asserted in the same cycle; mem_addr/mem_wdata SHALL stay stable while mem_waitrequest=1.
REQ-018 Minimum latency, acceptance to colour-write completion with zero wait states and mem_rvalid one cycle after read: 5 cycles.
REQ-019 done_in SHALL be latched sticky; done_out SHALL pulse for exactly one cycle when the latch is set and the FSM is IDLE with no pixel accepted in that cycle, then the latch clears.
REQ-020 If done_in and an accepted pixel coincide, done_out SHALL follow that pixel's completion.
REQ-021 Counters SHALL wrap from 32'hFFFFFFFF to 0.
REQ-022 mem_rvalid outside WAIT_Z SHALL be ignored.

Reset
REQ-023 Reset assertion SHALL immediately force IDLE, mem_read=0, mem_write=0, done_out=0, pix_stall=0, mem_addr=0, mem_wdata=0, counters=0 and done latch=0; an in-flight pixel SHALL be discarded.
REQ-024 Operation SHALL resume on the first rising edge after reset deassertion.

Configuration
REQ-025 Macro ZBUF_DEPTH_TEST_EN defined: behaviour as in REQ-011..016.
REQ-026 Macro ZBUF_DEPTH_TEST_EN undefined: IDLE SHALL go directly to WR_Z; RD_Z/WAIT_Z are unreachable; every pixel is written; pix_rejected stays 0.

Structure
REQ-027 Package zbuf_pkg SHALL hold the state enum, ADDR_W=26, COLOR_W=24, DEPTH_W=32 and DEPTH_FAR=32'h7FFFFFFF.
REQ-028 The block SHALL be a single module with no sub-modules.

Verification
REQ-029 Stored 32'h00050000, pixel addr 26'h000010 depth 32'h00020000 color 24'hFF8000 -> writes 32'h00020000 to 26'h0100010, then 32'h00FF8000 to 26'h000010; pix_written=1.
REQ-030 Stored 32'h00020000, pixel depth 32'h00020000 -> no mem_write; pix_rejected=1; pix_stall low again after WAIT_Z.
REQ-031 mem_waitrequest held 3 cycles in RD_Z and WR_C -> addresses stable; total latency 11 cycles; back-to-back pixel stalled throughout.
REQ-032 done_in pulsed with pixel acceptance -> done_out one cycle after that pixel's WR_C completes, exactly once.
REQ-033 Reset asserted during WR_Z -> mem_write drops asynchronously; after release no write for the discarded pixel; counters=0.
REQ-034 ZBUF_DEPTH_TEST_EN undefined, stored depth smaller -> both writes still occur; mem_read never asserted.
